// File: rtl/seg_pkg.sv
// Shared types, digit patterns and helpers for the 7-segment scan driver.
package seg_pkg;

  typedef logic [7:0] seg_pat_t;

  // Patterns are {a,b,c,d,e,f,g,dp}, active-low.
  localparam seg_pat_t SEG_BLANK = 8'hFF;
  localparam seg_pat_t SEG_D0    = 8'h03;
  localparam seg_pat_t SEG_D1    = 8'h9F;
  localparam seg_pat_t SEG_D2    = 8'h25;
  localparam seg_pat_t SEG_D3    = 8'h0D;
  localparam seg_pat_t SEG_D4    = 8'h99;
  localparam seg_pat_t SEG_D5    = 8'h49;
  localparam seg_pat_t SEG_D6    = 8'h41;
  localparam seg_pat_t SEG_D7    = 8'h1F;
  localparam seg_pat_t SEG_D8    = 8'h01;
  localparam seg_pat_t SEG_D9    = 8'h09;
  localparam seg_pat_t SEG_L     = 8'hE3;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {DRIVE, BLANK} scan_state_e;
  typedef enum logic [1:0] {RUN, BLINK, SOLID} mode_e;

  // Pattern bit 7 (a) lands on seg[0], bit 1 (g) on seg[6].
  function automatic logic [6:0] pat_to_seg(input seg_pat_t p);
    logic [6:0] s;
    for (int i = 0; i < 7; i++) s[i] = p[7-i];
    return s;
  endfunction

  // Counter width for a modulus, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Pattern inputs, game status and display pins of the scan driver.
// Optional SEG_DIM_EN adds the 2-bit brightness input dim.
interface seg_scan_driver_if;
  logic [7:0] seg_an3;
  logic [7:0] seg_an2;
  logic [7:0] seg_an1;
  logic [7:0] seg_an0;
  logic       start_game;
  logic       end_game;
  logic       lose;
`ifdef SEG_DIM_EN
  logic [1:0] dim;
`endif
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  modport master (
    output seg_an3, seg_an2, seg_an1, seg_an0, start_game, end_game, lose,
`ifdef SEG_DIM_EN
    output dim,
`endif
    input  seg, dp, an
  );

  modport slave (
    input  seg_an3, seg_an2, seg_an1, seg_an0, start_game, end_game, lose,
`ifdef SEG_DIM_EN
    input  dim,
`endif
    output seg, dp, an
  );
endinterface

// File: rtl/seg_scan_timer.sv
// DRIVE/BLANK phase counter and digit index; flags frame starts and the dim window.
// With SEG_DIM_EN the anode window shrinks to ((dim+1)*DIGIT_CYCLES)/4 cycles.
module seg_scan_timer
  import seg_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 2000
) (
  input  logic       clock,
  input  logic       reset_n,
`ifdef SEG_DIM_EN
  input  logic [1:0] dim,
`endif
  output logic [1:0] idx,
  output logic       in_drive,
  output logic       frame,
  output logic       gate
);

  localparam int unsigned CNT_W =
    cnt_w((DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST =
    CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DRIVE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Frame strobe marks the cycle whose edge moves the scan into index 0 DRIVE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    frame   = 1'b0;
    case (state_q)
      DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          cnt_d = '0;
          if (BLANK_CYCLES == 0) begin
            idx_d = idx_q + 2'd1;
            frame = (idx_q == 2'd3);
          end else begin
            state_d = BLANK;
          end
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = DRIVE;
          idx_d   = idx_q + 2'd1;
          frame   = (idx_q == 2'd3);
        end
      end
      default: state_d = DRIVE;
    endcase
  end

  assign idx      = idx_q;
  assign in_drive = (state_q == DRIVE);

`ifdef SEG_DIM_EN
  logic [31:0] on_limit;
  always_comb on_limit = ((32'(dim) + 32'd1) * DIGIT_CYCLES) / 32'd4;
  assign gate = (32'(cnt_q) < on_limit);
`else
  assign gate = 1'b1;
`endif

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexes four digit patterns onto a common-anode display; freezes the score at game end.
// Optional SEG_DIM_EN enables anode dimming through the dim input.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 2000,
  parameter int unsigned BLINK_CYCLES = 25000000
) (
  input logic               clock,
  input logic               reset_n,
  seg_scan_driver_if.slave  bus
);

  localparam int unsigned BLINK_W = cnt_w(BLINK_CYCLES);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  logic [1:0]         idx;
  logic               in_drive, frame, gate;
  mode_e              mode_q, mode_d;
  seg_pat_t           shadow_q [4];
  logic               eg_q, rise, load;
  logic               blink_on_q, blink_on_d;
  logic [BLINK_W-1:0] bcnt_q, bcnt_d;
  logic [3:0]         an_d, an_q;
  logic [6:0]         seg_d, seg_q;
  logic               dp_d, dp_q;

  seg_scan_timer #(
    .DIGIT_CYCLES (DIGIT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
`ifdef SEG_DIM_EN
    .dim      (bus.dim),
`endif
    .idx      (idx),
    .in_drive (in_drive),
    .frame    (frame),
    .gate     (gate)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q     <= RUN;
      eg_q       <= 1'b0;
      blink_on_q <= 1'b1;
      bcnt_q     <= '0;
      for (int i = 0; i < 4; i++) shadow_q[i] <= SEG_BLANK;
      an_q       <= AN_OFF;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
    end else begin
      mode_q     <= mode_d;
      eg_q       <= bus.end_game;
      blink_on_q <= blink_on_d;
      bcnt_q     <= bcnt_d;
      if (load) begin
        shadow_q[0] <= bus.seg_an0;
        shadow_q[1] <= bus.seg_an1;
        shadow_q[2] <= bus.seg_an2;
        shadow_q[3] <= bus.seg_an3;
      end
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  // Mode FSM: start_game low always wins; the end_game edge captures the score once.
  always_comb begin
    mode_d     = mode_q;
    load       = 1'b0;
    bcnt_d     = '0;
    blink_on_d = 1'b1;
    rise       = bus.end_game & ~eg_q;
    if (mode_q == RUN) load = frame;
    if (!bus.start_game) begin
      mode_d = RUN;
    end else if ((mode_q == RUN) && rise) begin
      mode_d = bus.lose ? BLINK : SOLID;
      load   = 1'b1;
    end
    if ((mode_q == BLINK) && (mode_d == BLINK)) begin
      bcnt_d     = bcnt_q + 1'b1;
      blink_on_d = blink_on_q;
      if (bcnt_q == BLINK_LAST) begin
        bcnt_d     = '0;
        blink_on_d = ~blink_on_q;
      end
    end
  end

  // Pin values for the current scan slot, registered one cycle later.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (in_drive) begin
      seg_d = pat_to_seg(shadow_q[idx]);
      dp_d  = shadow_q[idx][0];
      if (gate && !((mode_q == BLINK) && !blink_on_q)) an_d = ~(4'b0001 << idx);
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule
